// File: rtl/multiplicador_if.sv
// Handshake and data bundle for the signed Booth multiplier.
// The requester (master) drives the operands and the start pulse; the
// multiplier (slave) returns the product halves plus busy/done status.
interface multiplicador_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;
  logic             busy;
  logic             done;

  modport master (
    output start,
    output A,
    output B,
    input  Hi,
    input  Lo,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  A,
    input  B,
    output Hi,
    output Lo,
    output busy,
    output done
  );
endinterface

// File: rtl/multiplicador.sv
// Sequential signed multiplier using radix-2 Booth recoding, one
// iteration per clock. A request is accepted only in IDLE; the product
// appears on Hi/Lo together with a one-cycle done pulse WIDTH cycles later.
// Hi/Lo hold the last product until the next one completes or reset.
module multiplicador #(
  parameter int WIDTH = 32
) (
  input logic            clk,
  input logic            reset,
  multiplicador_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] q;
  logic             qm1;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  logic [WIDTH:0]   mcandExt;
  logic [WIDTH:0]   accSum;
  logic [WIDTH:0]   shAcc;
  logic [WIDTH-1:0] shQ;
  logic             shQm1;
  logic             lastIter;

  // Booth recoding of the current multiplier bit pair: add, subtract or
  // keep the multiplicand; the extra accumulator bit absorbs the carry that
  // the most negative multiplicand would otherwise overflow.
  always_comb begin
    mcandExt = {mcand[WIDTH-1], mcand};
    accSum   = acc;
    case ({q[0], qm1})
      2'b01:   accSum = acc + mcandExt;
      2'b10:   accSum = acc - mcandExt;
      default: accSum = acc;
    endcase
  end

  // Arithmetic right shift of the combined {acc, Q, Q(-1)} register by one.
  always_comb begin
    shAcc    = {accSum[WIDTH], accSum[WIDTH:1]};
    shQ      = {accSum[0], q[WIDTH-1:1]};
    shQm1    = q[0];
    lastIter = (cnt == LAST_ITER);
  end

  // Control FSM and datapath registers; reset wins over every transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      mcand <= '0;
      acc   <= '0;
      q     <= '0;
      qm1   <= 1'b0;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            mcand <= bus.A;
            q     <= bus.B;
            acc   <= '0;
            qm1   <= 1'b0;
            cnt   <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          acc <= shAcc;
          q   <= shQ;
          qm1 <= shQm1;
          cnt <= cnt + CW'(1);
          if (lastIter) begin
            hi    <= shAcc[WIDTH-1:0];
            lo    <= shQ;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.Hi   = hi;
  assign bus.Lo   = lo;
  assign bus.busy = (state == CALC);
  assign bus.done = (state == DONE);

endmodule

// File: tb/tb_multiplicador.sv
// Self-checking bench for the Booth multiplier: directed corner products,
// randomized operands against an arithmetic reference, start filtering,
// reset abort and back-to-back operation with start held high.
module tb_multiplicador;

  localparam int W = 32;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  multiplicador_if #(.WIDTH(W)) bus ();

  multiplicador #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Exact signed product, reduced modulo 2^(2W).
  function automatic logic [2*W-1:0] refProduct(input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
  endfunction

  // Pulse start for one cycle with the given operands; returns at the
  // falling edge right after the accepting rising edge.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.A     = a;
    bus.B     = b;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Run one multiplication and report what was observed (no judging here).
  task automatic doOperation(input logic [W-1:0] a, input logic [W-1:0] b,
                             output int busyCycles, output logic gotDone,
                             output logic [W-1:0] hi, output logic [W-1:0] lo,
                             output logic doneAfter);
    applyStimulus(a, b);
    busyCycles = 0;
    while (bus.busy === 1'b1 && busyCycles < 100) begin
      busyCycles++;
      @(negedge clk);
    end
    gotDone = bus.done;
    hi      = bus.Hi;
    lo      = bus.Lo;
    @(negedge clk);
    doneAfter = bus.done;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.Hi !== '0 || bus.Lo !== '0) begin
      failures++;
      $display("[TB] FAIL reset_hilo got Hi=%h Lo=%h want 0/0", bus.Hi, bus.Lo);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_flags got busy=%b done=%b want 0/0", bus.busy, bus.done);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_idle_after got busy=%b want 0", bus.busy);
    end
  endtask

  task automatic test_start_after_reset();
    int n;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset     = 1'b0;
    bus.A     = 32'd2;
    bus.B     = 32'd3;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL start_at_release got busy=%b want 1", bus.busy);
    end
    n = 0;
    while (bus.done !== 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (bus.done !== 1'b1 || bus.Lo !== 32'd6 || bus.Hi !== 32'd0) begin
      failures++;
      $display("[TB] FAIL start_at_release_result got done=%b Hi=%h Lo=%h want 1/0/6", bus.done, bus.Hi, bus.Lo);
    end
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [W-1:0] va [5];
    logic [W-1:0] vb [5];
    logic [W-1:0] eh [5];
    logic [W-1:0] el [5];
    int bc;
    logic gd, da;
    logic [W-1:0] h, l;
    va[0] = 32'd7;        vb[0] = 32'd6;        eh[0] = 32'h00000000; el[0] = 32'h0000002A;
    va[1] = 32'hFFFFFFFD; vb[1] = 32'd5;        eh[1] = 32'hFFFFFFFF; el[1] = 32'hFFFFFFF1;
    va[2] = 32'h80000000; vb[2] = 32'h80000000; eh[2] = 32'h40000000; el[2] = 32'h00000000;
    va[3] = 32'h7FFFFFFF; vb[3] = 32'hFFFFFFFF; eh[3] = 32'hFFFFFFFF; el[3] = 32'h80000001;
    va[4] = 32'h00000000; vb[4] = 32'hDEADBEEF; eh[4] = 32'h00000000; el[4] = 32'h00000000;
    for (int i = 0; i < 5; i++) begin
      doOperation(va[i], vb[i], bc, gd, h, l, da);
      checks++;
      if (bc != 32) begin
        failures++;
        $display("[TB] FAIL directed_latency[%0d] got %0d busy cycles want 32", i, bc);
      end
      checks++;
      if (gd !== 1'b1 || h !== eh[i] || l !== el[i]) begin
        failures++;
        $display("[TB] FAIL directed_product[%0d] got done=%b Hi=%h Lo=%h want 1 Hi=%h Lo=%h", i, gd, h, l, eh[i], el[i]);
      end
      checks++;
      if (da !== 1'b0) begin
        failures++;
        $display("[TB] FAIL directed_done_pulse[%0d] got done=%b one cycle later want 0", i, da);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] corner [4];
    logic [W-1:0] a, b;
    logic [2*W-1:0] exp;
    int bc;
    logic gd, da;
    logic [W-1:0] h, l;
    corner[0] = 32'h80000000;
    corner[1] = 32'hFFFFFFFF;
    corner[2] = 32'h7FFFFFFF;
    corner[3] = 32'h00000001;
    for (int i = 0; i < 20; i++) begin
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) a = corner[$urandom_range(0, 3)];
      if ($urandom_range(0, 3) == 0) b = corner[$urandom_range(0, 3)];
      exp = refProduct(a, b);
      doOperation(a, b, bc, gd, h, l, da);
      checks++;
      if (gd !== 1'b1 || {h, l} !== exp || bc != 32) begin
        failures++;
        $display("[TB] FAIL random_product A=%h B=%h got done=%b cyc=%0d %h_%h want %h", a, b, gd, bc, h, l, exp);
      end
    end
  endtask

  task automatic test_ignore_start();
    logic [W-1:0] oldHi, oldLo;
    logic [2*W-1:0] exp;
    int n;
    logic unstable;
    exp    = refProduct(32'd7, 32'd6);
    oldHi  = bus.Hi;
    oldLo  = bus.Lo;
    unstable = 1'b0;
    applyStimulus(32'd7, 32'd6);
    n = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      n++;
      if (bus.Hi !== oldHi || bus.Lo !== oldLo) unstable = 1'b1;
      bus.A     = $urandom;
      bus.B     = $urandom;
      bus.start = (n == 10);
      @(negedge clk);
    end
    bus.start = 1'b0;
    checks++;
    if (unstable) begin
      failures++;
      $display("[TB] FAIL ignore_hilo_stable got change during busy want Hi=%h Lo=%h held", oldHi, oldLo);
    end
    checks++;
    if (bus.done !== 1'b1 || {bus.Hi, bus.Lo} !== exp || n != 32) begin
      failures++;
      $display("[TB] FAIL ignore_result got done=%b cyc=%0d %h_%h want 1/32 %h", bus.done, n, bus.Hi, bus.Lo, exp);
    end
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ignore_start_in_done got busy=%b want 0", bus.busy);
    end
  endtask

  task automatic test_reset_midcalc();
    int bc;
    logic gd, da, sawDone;
    logic [W-1:0] h, l, a, b;
    applyStimulus(32'h12345678, 32'h9ABCDEF0);
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.Hi !== '0 || bus.Lo !== '0) begin
      failures++;
      $display("[TB] FAIL midcalc_reset got busy=%b done=%b Hi=%h Lo=%h want 0/0/0/0", bus.busy, bus.done, bus.Hi, bus.Lo);
    end
    sawDone = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) sawDone = 1'b1;
    end
    checks++;
    if (sawDone) begin
      failures++;
      $display("[TB] FAIL midcalc_no_done got activity after abort want none");
    end
    a = $urandom;
    b = $urandom;
    doOperation(a, b, bc, gd, h, l, da);
    checks++;
    if (gd !== 1'b1 || {h, l} !== refProduct(a, b)) begin
      failures++;
      $display("[TB] FAIL midcalc_restart got done=%b %h_%h want %h", gd, h, l, refProduct(a, b));
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] drvA, drvB, accA, accB;
    logic prevBusy;
    int cyc, lastRise, ops;
    @(negedge clk);
    drvA = $urandom;
    drvB = $urandom;
    accA = '0;
    accB = '0;
    bus.A     = drvA;
    bus.B     = drvB;
    bus.start = 1'b1;
    prevBusy  = 1'b0;
    cyc = 0;
    lastRise = -1;
    ops = 0;
    while (ops < 3 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (bus.busy === 1'b1 && !prevBusy) begin
        accA = drvA;
        accB = drvB;
        if (lastRise >= 0) begin
          checks++;
          if (cyc - lastRise != 34) begin
            failures++;
            $display("[TB] FAIL b2b_spacing got %0d cycles want 34", cyc - lastRise);
          end
        end
        lastRise = cyc;
      end
      if (bus.busy === 1'b1 && bus.done === 1'b1) begin
        checks++;
        failures++;
        $display("[TB] FAIL b2b_busy_done_overlap got busy=1 done=1 want exclusive");
      end
      if (bus.done === 1'b1) begin
        ops++;
        checks++;
        if ({bus.Hi, bus.Lo} !== refProduct(accA, accB)) begin
          failures++;
          $display("[TB] FAIL b2b_product A=%h B=%h got %h_%h want %h", accA, accB, bus.Hi, bus.Lo, refProduct(accA, accB));
        end
      end
      prevBusy = bus.busy;
      drvA  = $urandom;
      drvB  = $urandom;
      bus.A = drvA;
      bus.B = drvB;
    end
    bus.start = 1'b0;
    checks++;
    if (ops != 3) begin
      failures++;
      $display("[TB] FAIL b2b_timeout got %0d results want 3", ops);
    end
    repeat (40) @(negedge clk);
  endtask

  // Sequence of scenarios followed by the summary line.
  initial begin
    checks   = 0;
    failures = 0;
    $display("[TB] starting multiplicador bench");
    test_reset();
    test_start_after_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_reset_midcalc();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
